ahb_slave_mem: RTL and testbench
================================

Name: ahb_slave_mem

Overview:
- AHB slave with a word-addressed on-chip memory. It is the responder for the team's AHB bus-request master: it serves that master's 4-beat INCR read bursts at 0x1A00 and write bursts at 0x1B00.
- Supports programmable wait states, OKAY/ERROR responses and write-to-read forwarding.
- Sits behind the address decoder (hsel_i) on the shared AHB data bus.

Parameters:
- BASE_ADDR, 'h1A00, byte address of word 0.
- DEPTH, 128, number of 32-bit words; window is BASE_ADDR..BASE_ADDR+4*DEPTH-1 (0x1A00..0x1BFF).
- WAIT_CYCLES, 0, wait states inserted per OKAY transfer, range 0..7.

Ports:
- hclk_i  in  1  AHB clock.
- irst_n  in  1  reset, synchronous, active-low.
- hsel_i  in  1  slave select from decoder.
- haddr_i  in  32  byte address.
- htrans_i  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- hwrite_i  in  1  1 = write.
- hsize_i  in  3  transfer size; only 010 (word) is legal.
- hwdata_i  in  32  write data, valid in the data phase.
- hready_i  in  1  bus-level HREADY (mux of all slaves).
- hrdata_o  out  32  read data.
- hready_o  out  1  this slave's HREADYOUT.
- hresp_o  out  2  00 OKAY, 01 ERROR.

Behaviour:
- Reset: irst_n sampled low at a hclk_i rising edge forces:
  - FSM to IDLE; hready_o=1, hresp_o=00, hrdata_o=0;
  - the wait counter and any pending write are cleared; a reset mid-burst discards the in-flight write.
  - Memory contents are not reset.
- Address phase accepted when hsel_i & hready_i & htrans_i[1] at a rising edge. Captured: address word index (haddr_i-BASE_ADDR)>>2, hwrite_i, and an error flag.
- Error flag is set if any of the following hold:
  - haddr_i is outside the window;
  - haddr_i[1:0]!=0;
  - hsize_i!=010.
- IDLE/BUSY transfers, or hsel_i=0, are not captured. The slave stays or returns to IDLE with a zero-wait OKAY (hready_o=1, hresp_o=00).
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2. Transitions from each state:
  - IDLE/DATA:
    - accepted good transfer with WAIT_CYCLES>0 -> WAIT (hready_o=0, counter loaded with WAIT_CYCLES-1);
    - accepted good transfer with WAIT_CYCLES=0 -> DATA (hready_o=1);
    - accepted bad transfer -> ERR1;
    - otherwise -> IDLE.
  - WAIT: hready_o=0; counter decrements each cycle; at 0 -> DATA.
  - DATA: hready_o=1, hresp_o=00; data phase completes this cycle. Can accept a new address phase in the same cycle (pipelined back-to-back bursts).
  - ERR1: hready_o=0, hresp_o=01 -> ERR2.
  - ERR2: hready_o=1, hresp_o=01; may accept the next transfer (same rules as IDLE/DATA). An ERROR transfer never writes memory and does not update hrdata_o.
- Read: hrdata_o is registered from memory at the edge that accepts the address phase, and held until the next accepted read. It is valid throughout WAIT and DATA.
- Write: memory is written with hwdata_i at the rising edge ending the DATA cycle (hready_o=1 in DATA).
- Forwarding: if a read is accepted at the same edge that commits a write to the same word, hrdata_o takes hwdata_i, not the stale memory word.
- Address phases presented while hready_o=0 are ignored (hready_i is low). The master holds them, and they are accepted when hready goes high.
- The word index is computed in 32 bits. Underflow (haddr_i<BASE_ADDR) is an error, not a wrap.

Test Plan:
- Reset mid-burst: assert reset during the data phase of a write to 0x1B04 -> next cycle hready_o=1, hresp_o=00, hrdata_o=0; 0x1B04 is unchanged.
- WAIT_CYCLES=0, 4-beat INCR write 0x1B00..0x1B0C with data 0x11,0x22,0x33,0x44, then 4-beat read from 0x1B00 -> hready_o stays 1; reads return 0x11,0x22,0x33,0x44 on consecutive data phases.
- WAIT_CYCLES=2, single read of 0x1A08 holding 0xDEADBEEF -> hready_o low 2 cycles, then high with hrdata_o=0xDEADBEEF, hresp_o=00.
- Write 0xCAFE0001 to 0x1A10 immediately followed by NONSEQ read of 0x1A10 (forwarding case) -> read data phase returns 0xCAFE0001.
- NONSEQ read of 0x1C00 (out of window), then misaligned 0x1A02, then hsize=000 -> each gives hresp_o=01 with hready_o 0 then 1 (two cycles); memory and hrdata_o are unchanged.
- BUSY mid-burst and hsel_i=0 with htrans_i=NONSEQ -> zero-wait OKAY, no memory write; the following SEQ beat completes normally.

Source files
------------

// File: rtl/ahb_slave_mem.sv
// AHB slave backed by a word-addressed on-chip memory: programmable wait states,
// OKAY/ERROR responses and forwarding of a committing write to a same-cycle read.
module ahb_slave_mem #(
    parameter logic [31:0] BASE_ADDR   = 32'h1A00,
    parameter int unsigned DEPTH       = 128,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        hclk_i,
    input  logic        irst_n,
    input  logic        hsel_i,
    input  logic [31:0] haddr_i,
    input  logic [1:0]  htrans_i,
    input  logic        hwrite_i,
    input  logic [2:0]  hsize_i,
    input  logic [31:0] hwdata_i,
    input  logic        hready_i,
    output logic [31:0] hrdata_o,
    output logic        hready_o,
    output logic [1:0]  hresp_o
);

    localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] WIN_BYTES = 32'(4 * DEPTH);
    localparam logic [2:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_ERR1 = 3'd3;
    localparam logic [2:0] S_ERR2 = 3'd4;

    logic [31:0]   mem [0:DEPTH-1];
    logic [2:0]    state, state_d;
    logic [2:0]    cnt, cnt_d;
    logic [AW-1:0] addr_q;
    logic          wr_q;
    logic [31:0]   rdata_q;

    logic [31:0]   off;
    logic [AW-1:0] idx;
    logic          bad;
    logic          can_accept;
    logic          accept;
    logic          wr_commit;
    logic [31:0]   rd_word;
    logic          unused_bits;

    // Underflow wraps off to a huge value; the explicit compare keeps the intent obvious.
    assign off        = haddr_i - BASE_ADDR;
    assign idx        = off[AW+1:2];
    assign bad        = (haddr_i < BASE_ADDR) || (off >= WIN_BYTES) ||
                        (haddr_i[1:0] != 2'b00) || (hsize_i != 3'b010);
    assign can_accept = (state == S_IDLE) || (state == S_DATA) || (state == S_ERR2);
    assign accept     = can_accept && hsel_i && hready_i && htrans_i[1];
    assign wr_commit  = (state == S_DATA) && wr_q;
    assign rd_word    = (wr_commit && (addr_q == idx)) ? hwdata_i : mem[idx];
    assign unused_bits = ^{htrans_i[0], off[1:0]};

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            S_IDLE, S_DATA, S_ERR2: begin
                if (!accept) begin
                    state_d = S_IDLE;
                end else if (bad) begin
                    state_d = S_ERR1;
                end else if (WAIT_CYCLES > 0) begin
                    state_d = S_WAIT;
                    cnt_d   = WAIT_LOAD;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_WAIT: begin
                if (cnt == 3'd0) begin
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt - 3'd1;
                end
            end
            S_ERR1:  state_d = S_ERR2;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge hclk_i) begin
        if (!irst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (accept) begin
                wr_q <= hwrite_i && !bad;
                if (!bad) begin
                    addr_q <= idx;
                    if (!hwrite_i) begin
                        rdata_q <= rd_word;
                    end
                end
            end
        end
    end

    // Storage is not reset; a reset edge still suppresses the in-flight write.
    always_ff @(posedge hclk_i) begin
        if (irst_n && wr_commit) begin
            mem[addr_q] <= hwdata_i;
        end
    end

    assign hrdata_o = rdata_q;
    assign hready_o = !((state == S_WAIT) || (state == S_ERR1));
    assign hresp_o  = ((state == S_ERR1) || (state == S_ERR2)) ? 2'b01 : 2'b00;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench for ahb_slave_mem: one zero-wait and one two-wait instance
// sharing an AHB bus, with hand-computed expected values.
module tb_ahb_slave_mem;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    logic        hclk = 1'b0;
    logic        irst_n = 1'b0;
    logic        hsel0 = 1'b0;
    logic        hsel2 = 1'b0;
    logic [31:0] haddr = '0;
    logic [1:0]  htrans = T_IDLE;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'b010;
    logic [31:0] hwdata = '0;
    logic        hready_bus;
    logic [31:0] rdata0, rdata2;
    logic        rdy0, rdy2;
    logic [1:0]  resp0, resp2;

    int unsigned checks = 0;
    int unsigned errors = 0;

    assign hready_bus = rdy0 & rdy2;

    always #5 hclk = ~hclk;

    ahb_slave_mem #(.BASE_ADDR(32'h1A00), .DEPTH(128), .WAIT_CYCLES(0)) u_mem0 (
        .hclk_i(hclk), .irst_n(irst_n), .hsel_i(hsel0), .haddr_i(haddr),
        .htrans_i(htrans), .hwrite_i(hwrite), .hsize_i(hsize), .hwdata_i(hwdata),
        .hready_i(hready_bus), .hrdata_o(rdata0), .hready_o(rdy0), .hresp_o(resp0)
    );

    ahb_slave_mem #(.BASE_ADDR(32'h1A00), .DEPTH(128), .WAIT_CYCLES(2)) u_mem2 (
        .hclk_i(hclk), .irst_n(irst_n), .hsel_i(hsel2), .haddr_i(haddr),
        .htrans_i(htrans), .hwrite_i(hwrite), .hsize_i(hsize), .hwdata_i(hwdata),
        .hready_i(hready_bus), .hrdata_o(rdata2), .hready_o(rdy2), .hresp_o(resp2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic ap(input logic s0, input logic s2, input logic [31:0] a,
                      input logic [1:0] t, input logic w);
        hsel0  = s0;
        hsel2  = s2;
        haddr  = a;
        htrans = t;
        hwrite = w;
    endtask

    task automatic idle();
        ap(1'b0, 1'b0, 32'h0, T_IDLE, 1'b0);
    endtask

    // Single zero-wait read on u_mem0; leaves the bus idle after the data phase.
    task automatic rd0(input string tag, input logic [31:0] a, input logic [31:0] exp);
        ap(1'b1, 1'b0, a, T_NONSEQ, 1'b0);
        tick();
        idle();
        chk(tag, rdata0, exp);
        tick();
    endtask

    logic [31:0] wdat [4];

    initial begin
        wdat[0] = 32'h11; wdat[1] = 32'h22; wdat[2] = 32'h33; wdat[3] = 32'h44;

        tick();
        tick();
        chk("rst_hready0", 32'(rdy0), 32'd1);
        chk("rst_hresp0", 32'(resp0), 32'd0);
        chk("rst_hrdata0", rdata0, 32'h0);
        chk("rst_hready2", 32'(rdy2), 32'd1);
        irst_n = 1'b1;
        tick();

        // Zero-wait 4-beat write burst then 4-beat read burst
        for (int i = 0; i < 4; i++) begin
            ap(1'b1, 1'b0, 32'h1B00 + 32'(4 * i), (i == 0) ? T_NONSEQ : T_SEQ, 1'b1);
            tick();
            chk("wr_burst_hready", 32'(rdy0), 32'd1);
            hwdata = wdat[i];
        end
        for (int i = 0; i < 4; i++) begin
            ap(1'b1, 1'b0, 32'h1B00 + 32'(4 * i), (i == 0) ? T_NONSEQ : T_SEQ, 1'b0);
            tick();
            hwdata = 32'h0;
            chk("rd_burst_hready", 32'(rdy0), 32'd1);
            chk("rd_burst_data", rdata0, wdat[i]);
        end
        idle();
        tick();

        // Reset during the data phase of a write to 0x1B04
        ap(1'b1, 1'b0, 32'h1B04, T_NONSEQ, 1'b1);
        tick();
        idle();
        hwdata = 32'h99;
        irst_n = 1'b0;
        tick();
        irst_n = 1'b1;
        chk("midrst_hready", 32'(rdy0), 32'd1);
        chk("midrst_hresp", 32'(resp0), 32'd0);
        chk("midrst_hrdata", rdata0, 32'h0);
        tick();
        rd0("midrst_mem", 32'h1B04, 32'h22);

        // Write immediately followed by a read of the same word
        ap(1'b1, 1'b0, 32'h1A10, T_NONSEQ, 1'b1);
        tick();
        hwdata = 32'hCAFE0001;
        ap(1'b1, 1'b0, 32'h1A10, T_NONSEQ, 1'b0);
        tick();
        idle();
        chk("fwd_data", rdata0, 32'hCAFE0001);
        tick();
        rd0("fwd_mem", 32'h1A10, 32'hCAFE0001);

        // Error responses: out of window, misaligned, bad size (as a write)
        ap(1'b1, 1'b0, 32'h1C00, T_NONSEQ, 1'b0);
        tick();
        idle();
        chk("err_oow_e1_rdy", 32'(rdy0), 32'd0);
        chk("err_oow_e1_resp", 32'(resp0), 32'd1);
        tick();
        chk("err_oow_e2_rdy", 32'(rdy0), 32'd1);
        chk("err_oow_e2_resp", 32'(resp0), 32'd1);
        chk("err_oow_hrdata", rdata0, 32'hCAFE0001);
        ap(1'b1, 1'b0, 32'h1A02, T_NONSEQ, 1'b0);
        tick();
        idle();
        chk("err_mis_e1_rdy", 32'(rdy0), 32'd0);
        chk("err_mis_e1_resp", 32'(resp0), 32'd1);
        tick();
        chk("err_mis_e2_rdy", 32'(rdy0), 32'd1);
        chk("err_mis_e2_resp", 32'(resp0), 32'd1);
        hsize = 3'b000;
        ap(1'b1, 1'b0, 32'h1A10, T_NONSEQ, 1'b1);
        tick();
        hsize = 3'b010;
        idle();
        hwdata = 32'hBAD0BAD0;
        chk("err_sz_e1_rdy", 32'(rdy0), 32'd0);
        chk("err_sz_e1_resp", 32'(resp0), 32'd1);
        tick();
        chk("err_sz_e2_rdy", 32'(rdy0), 32'd1);
        chk("err_sz_e2_resp", 32'(resp0), 32'd1);
        chk("err_sz_hrdata", rdata0, 32'hCAFE0001);
        tick();
        chk("err_back_resp", 32'(resp0), 32'd0);
        rd0("err_sz_mem", 32'h1A10, 32'hCAFE0001);

        // BUSY mid-burst and a deselected NONSEQ must not write
        ap(1'b1, 1'b0, 32'h1A28, T_NONSEQ, 1'b1);
        tick();
        hwdata = 32'h5555;
        ap(1'b1, 1'b0, 32'h1A20, T_NONSEQ, 1'b1);
        tick();
        hwdata = 32'hA1;
        ap(1'b1, 1'b0, 32'h1A28, T_BUSY, 1'b1);
        tick();
        hwdata = 32'hBAD1;
        chk("busy_hready", 32'(rdy0), 32'd1);
        chk("busy_hresp", 32'(resp0), 32'd0);
        ap(1'b0, 1'b0, 32'h1A28, T_NONSEQ, 1'b1);
        tick();
        hwdata = 32'hBAD2;
        chk("nosel_hready", 32'(rdy0), 32'd1);
        chk("nosel_hresp", 32'(resp0), 32'd0);
        ap(1'b1, 1'b0, 32'h1A24, T_SEQ, 1'b1);
        tick();
        hwdata = 32'hA2;
        idle();
        chk("seq_hready", 32'(rdy0), 32'd1);
        tick();
        rd0("busy_beat0", 32'h1A20, 32'hA1);
        rd0("busy_beat1", 32'h1A24, 32'hA2);
        rd0("busy_nowrite", 32'h1A28, 32'h5555);

        // Two wait states on u_mem2: preload 0x1A08 then read it back
        ap(1'b0, 1'b1, 32'h1A08, T_NONSEQ, 1'b1);
        tick();
        idle();
        hwdata = 32'hDEADBEEF;
        chk("w2_wr_wait0", 32'(rdy2), 32'd0);
        tick();
        chk("w2_wr_wait1", 32'(rdy2), 32'd0);
        tick();
        chk("w2_wr_data", 32'(rdy2), 32'd1);
        tick();
        hwdata = 32'h0;
        ap(1'b0, 1'b1, 32'h1A08, T_NONSEQ, 1'b0);
        tick();
        idle();
        chk("w2_rd_wait0", 32'(rdy2), 32'd0);
        tick();
        chk("w2_rd_wait1", 32'(rdy2), 32'd0);
        tick();
        chk("w2_rd_hready", 32'(rdy2), 32'd1);
        chk("w2_rd_hresp", 32'(resp2), 32'd0);
        chk("w2_rd_data", rdata2, 32'hDEADBEEF);
        tick();
        chk("w2_idle_hready", 32'(rdy2), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
